// File: rtl/edge_counter_pkg.sv
// Shared definitions for the edge counter / window controller slice:
// default widths, drain depth and controller state encoding.
package edge_counter_pkg;

    localparam int COUNT_W_DEF      = 8;
    localparam int WIN_W_DEF        = 16;
    localparam int DRAIN_CYCLES_DEF = 2;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] COUNT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

endpackage

// File: rtl/edge_window_ctrl_if.sv
// Control, counter-side and result handshake signals of the window controller.
// The controller takes the slave view; the control master / bench takes the master view.
interface edge_window_ctrl_if
    import edge_counter_pkg::*;
#(
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int WIN_W   = WIN_W_DEF
) ();

    logic               in_start;
    logic               in_abort;
    logic               in_continuous;
    logic [WIN_W-1:0]   in_window_len;
    logic [COUNT_W-1:0] in_count_value;
    logic               out_counter_clear;
    logic               out_gate;
    logic               out_busy;
    logic [COUNT_W-1:0] out_result;
    logic               out_result_valid;
    logic               in_result_ready;
    logic               out_error;

    modport slave (
        input  in_start, in_abort, in_continuous, in_window_len, in_count_value, in_result_ready,
        output out_counter_clear, out_gate, out_busy, out_result, out_result_valid, out_error
    );

    modport master (
        output in_start, in_abort, in_continuous, in_window_len, in_count_value, in_result_ready,
        input  out_counter_clear, out_gate, out_busy, out_result, out_result_valid, out_error
    );

endinterface

// File: rtl/window_timer.sv
// Loadable down-counter shared by the counting window and the pipeline drain.
// Load wins over decrement; the count holds at zero.
module window_timer #(
    parameter int WIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIN_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIN_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/edge_window_ctrl.sv
// Gated event meter sequencer: clears the edge counter, opens a window of
// programmable length, waits for the counter pipeline to drain, then offers the count.
module edge_window_ctrl
    import edge_counter_pkg::*;
#(
    parameter int COUNT_W      = COUNT_W_DEF,
    parameter int WIN_W        = WIN_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic              in_clock,
    input  logic              in_reset,
    edge_window_ctrl_if.slave bus
);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [WIN_W-1:0]   len_q;
    logic [COUNT_W-1:0] result_q;
    logic               clear_q;
    logic               gate_q;
    logic               busy_q;
    logic               valid_q;
    logic               err_q;

    logic               len_ok;
    logic               latch_len;
    logic               capture;
    logic               err_nxt;
    logic               tmr_load;
    logic               tmr_dec;
    logic               tmr_zero;
    logic [WIN_W-1:0]   tmr_val;

    window_timer #(.WIN_W(WIN_W)) u_timer (
        .clk      (in_clock),
        .rst      (in_reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign len_ok = (bus.in_window_len != '0);

    // Abort overrides everything, including a simultaneous start in IDLE.
    always_comb begin
        state_nxt = state;
        latch_len = 1'b0;
        capture   = 1'b0;
        err_nxt   = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = '0;
        if (bus.in_abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_start) begin
                        if (len_ok) begin
                            state_nxt = CLEAR;
                            latch_len = 1'b1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state_nxt = COUNT;
                    tmr_load  = 1'b1;
                    tmr_val   = len_q - 1'b1;
                end
                COUNT: begin
                    if (tmr_zero) begin
                        state_nxt = DRAIN;
                        tmr_load  = 1'b1;
                        tmr_val   = WIN_W'(DRAIN_CYCLES - 1);
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                DRAIN: begin
                    if (tmr_zero) begin
                        state_nxt = HOLD;
                        capture   = 1'b1;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                HOLD: begin
                    // A start arriving alongside the handshake is deliberately not looked at here.
                    if (bus.in_result_ready) begin
                        if (bus.in_continuous && len_ok) begin
                            state_nxt = CLEAR;
                            latch_len = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            err_nxt   = bus.in_continuous;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered straight from the next-state decode so they line up with state.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            state    <= IDLE;
            len_q    <= '0;
            result_q <= '0;
            clear_q  <= 1'b0;
            gate_q   <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            clear_q <= (state_nxt == CLEAR);
            gate_q  <= (state_nxt == COUNT);
            busy_q  <= (state_nxt != IDLE);
            valid_q <= (state_nxt == HOLD);
            err_q   <= err_nxt;
            if (latch_len) begin
                len_q <= bus.in_window_len;
            end
            if (capture) begin
                result_q <= bus.in_count_value;
            end
        end
    end

    assign bus.out_counter_clear = clear_q;
    assign bus.out_gate          = gate_q;
    assign bus.out_busy          = busy_q;
    assign bus.out_result_valid  = valid_q;
    assign bus.out_result        = result_q;
    assign bus.out_error         = err_q;

endmodule

// File: tb/tb_edge_window_ctrl.sv
// Bench for edge_window_ctrl: drives an edge detector + counter model through the
// controller and compares each captured count with a count of input rises in the window.
module tb_edge_window_ctrl;
    import edge_counter_pkg::*;

    localparam int COUNT_W = 8;
    localparam int WIN_W   = 16;
    localparam int HIST_N  = 16384;

    logic in_clock = 1'b0;
    logic in_reset;
    logic in_signal;

    always #5 in_clock = ~in_clock;

    edge_window_ctrl_if #(.COUNT_W(COUNT_W), .WIN_W(WIN_W)) bus ();

    edge_window_ctrl #(.COUNT_W(COUNT_W), .WIN_W(WIN_W), .DRAIN_CYCLES(2)) dut (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .bus      (bus)
    );

    // External datapath: registered rising-edge strobe feeding a clearable counter.
    logic               sig_d;
    logic               strobe_q;
    logic [COUNT_W-1:0] cnt_q;

    always_ff @(posedge in_clock) begin
        sig_d    <= in_signal;
        strobe_q <= in_signal & ~sig_d;
        if (in_reset || bus.out_counter_clear) begin
            cnt_q <= '0;
        end else if (strobe_q && bus.out_gate) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.in_count_value = cnt_q;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int sig_mode;
    int sig_target;
    bit sig_hist [HIST_N];

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge in_clock);
        #1;
        cyc++;
        if (cyc >= HIST_N) begin
            $display("FAIL cycle_budget: got %0d expected < %0d", cyc, HIST_N);
            $fatal(1, "cycle budget exhausted");
        end
        case (sig_mode)
            0:       in_signal = 1'b0;
            1:       in_signal = ~in_signal;
            2:       in_signal = 1'($urandom_range(0, 1));
            default: in_signal = (cyc == sig_target);
        endcase
        sig_hist[cyc] = in_signal;
    endtask

    // A window accepted at cycle s counts rises of in_signal at cycles s+1 .. s+len
    // (the strobe for a rise at c is one cycle later, inside the gate).
    function automatic int ref_count(input int s, input int len);
        int n = 0;
        for (int c = s + 1; c <= s + len; c++) begin
            if (sig_hist[c] && !sig_hist[c-1]) n++;
        end
        return n % (1 << COUNT_W);
    endfunction

    task automatic do_start(input int len, output int s);
        bus.in_window_len = WIN_W'(len);
        bus.in_start      = 1'b1;
        s = cyc;
        tick();
        bus.in_start      = 1'b0;
    endtask

    task automatic collect(input int s, input int len, input int rdy_dly, input bit cont,
                           input int next_len, input bit poke, input bit start_hs,
                           input int exp_fixed, output int h);
        int gates = 0;
        int exp_v;
        chk_eq("clear_pulse", int'(bus.out_counter_clear), 1);
        chk_eq("busy_in_clear", int'(bus.out_busy), 1);
        while (!bus.out_result_valid && cyc < s + len + 40) begin
            gates += int'(bus.out_gate);
            bus.in_start = poke && (cyc == s + len + 2);
            tick();
        end
        bus.in_start = 1'b0;
        chk_eq("gate_cycles", gates, len);
        chk_eq("latency", cyc - s, len + 4);
        exp_v = (exp_fixed >= 0) ? exp_fixed : ref_count(s, len);
        chk_eq("result", int'(bus.out_result), exp_v);
        for (int i = 0; i < rdy_dly; i++) begin
            tick();
            chk_eq("hold_valid", int'(bus.out_result_valid), 1);
            chk_eq("hold_result", int'(bus.out_result), exp_v);
        end
        bus.in_result_ready = 1'b1;
        bus.in_continuous   = cont;
        bus.in_window_len   = WIN_W'(next_len);
        bus.in_start        = start_hs;
        h = cyc;
        tick();
        bus.in_result_ready = 1'b0;
        bus.in_continuous   = 1'b0;
        bus.in_start        = 1'b0;
        chk_eq("valid_drop", int'(bus.out_result_valid), 0);
        chk_eq("err_after_hs", int'(bus.out_error), int'(cont && next_len == 0));
        if (!(cont && next_len != 0)) chk_eq("idle_after_hs", int'(bus.out_busy), 0);
    endtask

    initial begin
        int s;
        int h;
        int v;
        int len;
        int nl;
        bit cont;
        cyc        = 0;
        sig_mode   = 0;
        sig_target = -1;
        in_signal  = 1'b0;
        sig_hist[0] = 1'b0;
        in_reset   = 1'b1;
        bus.in_start        = 1'b0;
        bus.in_abort        = 1'b0;
        bus.in_continuous   = 1'b0;
        bus.in_window_len   = '0;
        bus.in_result_ready = 1'b0;
        repeat (3) tick();

        chk_eq("rst_busy", int'(bus.out_busy), 0);
        chk_eq("rst_gate", int'(bus.out_gate), 0);
        chk_eq("rst_clear", int'(bus.out_counter_clear), 0);
        chk_eq("rst_valid", int'(bus.out_result_valid), 0);
        chk_eq("rst_result", int'(bus.out_result), 0);
        chk_eq("rst_error", int'(bus.out_error), 0);
        in_reset = 1'b0;
        tick();

        // len=10 with the input toggling every clock: five rises in the window.
        sig_mode = 1;
        do_start(10, s);
        collect(s, 10, 2, 1'b0, 0, 1'b1, 1'b0, 5, h);

        // Zero-length start.
        sig_mode = 0;
        do_start(0, s);
        chk_eq("zero_len_error", int'(bus.out_error), 1);
        chk_eq("zero_len_busy", int'(bus.out_busy), 0);
        chk_eq("zero_len_clear", int'(bus.out_counter_clear), 0);
        tick();
        chk_eq("zero_len_error_pulse", int'(bus.out_error), 0);

        // Continuous re-arm with a slow consumer, then re-arm with zero length.
        sig_mode = 2;
        do_start(4, s);
        collect(s, 4, 5, 1'b1, 4, 1'b0, 1'b0, -1, h);
        collect(h, 4, 0, 1'b1, 0, 1'b0, 1'b0, -1, h);
        tick();

        // Abort in the middle of the window.
        do_start(20, s);
        repeat (6) tick();
        chk_eq("gate_before_abort", int'(bus.out_gate), 1);
        bus.in_abort = 1'b1;
        tick();
        bus.in_abort = 1'b0;
        chk_eq("abort_gate", int'(bus.out_gate), 0);
        chk_eq("abort_busy", int'(bus.out_busy), 0);
        v = 0;
        repeat (30) begin
            tick();
            v += int'(bus.out_result_valid) + int'(bus.out_busy);
        end
        chk_eq("abort_stays_idle", v, 0);
        do_start(8, s);
        collect(s, 8, 1, 1'b0, 0, 1'b0, 1'b0, -1, h);

        // Abort and zero-length start together: no error.
        bus.in_abort      = 1'b1;
        bus.in_start      = 1'b1;
        bus.in_window_len = '0;
        tick();
        bus.in_abort = 1'b0;
        bus.in_start = 1'b0;
        chk_eq("abort_start_error", int'(bus.out_error), 0);
        chk_eq("abort_start_busy", int'(bus.out_busy), 0);

        // Start coinciding with a non-continuous handshake is dropped.
        sig_mode = 1;
        do_start(5, s);
        collect(s, 5, 0, 1'b0, 5, 1'b0, 1'b1, -1, h);
        tick();
        chk_eq("hs_start_ignored", int'(bus.out_busy), 0);

        // Window edge alignment with single pulses on in_signal.
        sig_mode = 3;
        sig_target = cyc + 1 + 6; tick(); do_start(6, s);
        collect(s, 6, 0, 1'b0, 0, 1'b0, 1'b0, 1, h);
        sig_target = cyc + 1 + 7; tick(); do_start(6, s);
        collect(s, 6, 0, 1'b0, 0, 1'b0, 1'b0, 0, h);
        sig_target = cyc + 1 + 1; tick(); do_start(6, s);
        collect(s, 6, 0, 1'b0, 0, 1'b0, 1'b0, 1, h);
        sig_target = cyc + 1; tick(); do_start(6, s);
        collect(s, 6, 0, 1'b0, 0, 1'b0, 1'b0, 0, h);

        // Reset while a result is held clears everything including the result.
        sig_mode = 1;
        do_start(3, s);
        v = 0;
        while (!bus.out_result_valid && v < 40) begin
            tick();
            v++;
        end
        chk_eq("reached_hold", int'(bus.out_result_valid), 1);
        in_reset = 1'b1;
        tick();
        chk_eq("hold_rst_valid", int'(bus.out_result_valid), 0);
        chk_eq("hold_rst_result", int'(bus.out_result), 0);
        chk_eq("hold_rst_busy", int'(bus.out_busy), 0);
        in_reset = 1'b0;
        tick();

        // Randomized measurements, some chained through continuous mode.
        repeat (25) begin
            sig_mode = int'($urandom_range(1, 2));
            len  = int'($urandom_range(1, 24));
            nl   = int'($urandom_range(1, 24));
            cont = 1'($urandom_range(0, 1));
            do_start(len, s);
            collect(s, len, int'($urandom_range(0, 3)), cont, nl, 1'($urandom_range(0, 1)), 1'b0, -1, h);
            if (cont) collect(h, nl, int'($urandom_range(0, 3)), 1'b0, 0, 1'b0, 1'b0, -1, h);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
